// File: rtl/gb_custom_wave_channel_if.sv
// Channel 3 bundle: control inputs, wave-RAM read port and mixer-facing outputs.
interface gb_custom_wave_channel_if;
  logic        clk_length_ctr;
  logic [7:0]  length;
  logic [1:0]  volume;
  logic        on;
  logic        single;
  logic        start;
  logic [10:0] frequency;
  logic [7:0]  wave_data;
  logic [3:0]  wave_addr;
  logic [3:0]  level;
  logic        enable;

  modport master (
    output clk_length_ctr, length, volume, on, single, start, frequency, wave_data,
    input  wave_addr, level, enable
  );

  modport slave (
    input  clk_length_ctr, length, volume, on, single, start, frequency, wave_data,
    output wave_addr, level, enable
  );
endinterface

// File: rtl/gb_custom_wave_channel.sv
// Game Boy APU channel 3: steps a 32-nibble wave table at 2048-frequency clocks per nibble.
// Optional length timeout is compiled in with GB_CH3_LENGTH_EN.
module gb_custom_wave_channel (
  input logic                     clk,
  input logic                     reset,
  gb_custom_wave_channel_if.slave bus
);
  localparam int unsigned TIMER_W = 11;
  localparam int unsigned POS_W   = 5;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned NIB_W   = 4;

  logic               start_q;
  logic               enable_q;
  logic [TIMER_W-1:0] timer;
  logic [POS_W-1:0]   pos;
  logic               trigger_c;
  logic               load_c;
  logic               expire_c;
  logic [TIMER_W-1:0] period_c;
  logic [NIB_W-1:0]   nibble_c;
  logic [NIB_W-1:0]   level_c;

  assign trigger_c = bus.start & ~start_q;
  assign load_c    = trigger_c & bus.on;
  // A period of 2048 truncates to 0, so the countdown runs 0,2047..1 and still spans 2048 clocks
  assign period_c  = TIMER_W'(12'd2048 - {1'b0, bus.frequency});

`ifdef GB_CH3_LENGTH_EN
  logic [LEN_W-1:0] len_cnt;

  // Length counter: reload on trigger, count down on each length tick until zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_cnt <= '0;
    end else if (load_c) begin
      len_cnt <= LEN_W'(9'd256 - {1'b0, bus.length});
    end else if (bus.clk_length_ctr && (len_cnt != '0)) begin
      len_cnt <= len_cnt - LEN_W'(1);
    end
  end

  assign expire_c = ~load_c & bus.clk_length_ctr & bus.single & (len_cnt == LEN_W'(1));
`else
  assign expire_c = 1'b0;
`endif

  // Trigger edge detect and channel enable; DAC off has highest priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      start_q <= bus.start;
      if (!bus.on) begin
        enable_q <= 1'b0;
      end else if (trigger_c) begin
        enable_q <= 1'b1;
      end else if (expire_c) begin
        enable_q <= 1'b0;
      end
    end
  end

  // Frequency timer and wave position
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
      pos   <= '0;
    end else if (load_c) begin
      timer <= period_c;
      pos   <= '0;
    end else if (enable_q) begin
      if (timer == TIMER_W'(1)) begin
        timer <= period_c;
        pos   <= pos + POS_W'(1);
      end else begin
        timer <= timer - TIMER_W'(1);
      end
    end
  end

  // Nibble select and volume shift straight from wave RAM
  always_comb begin
    nibble_c = pos[0] ? bus.wave_data[3:0] : bus.wave_data[7:4];
    level_c  = '0;
    if (enable_q) begin
      case (bus.volume)
        2'd0:    level_c = '0;
        2'd1:    level_c = nibble_c;
        2'd2:    level_c = nibble_c >> 1;
        default: level_c = nibble_c >> 2;
      endcase
    end
  end

  assign bus.wave_addr = pos[POS_W-1:1];
  assign bus.level     = level_c;
  assign bus.enable    = enable_q;
endmodule

// File: tb/tb_gb_custom_wave_channel.sv
// Self-checking bench for gb_custom_wave_channel: directed table, corner sequences, random vs model.
module tb_gb_custom_wave_channel;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] ram [16];

  gb_custom_wave_channel_if bus ();

  gb_custom_wave_channel dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.wave_data = ram[bus.wave_addr];

  always #5 clk = ~clk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  typedef struct {
    int vol;
    int k;
    int lvl;
    int addr;
    int en;
  } vec_t;

  vec_t tbl [13];

  // behavioural model state
  int m_en, m_pos, m_rem, m_len, m_prev;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    bus.clk_length_ctr = 1'b0;
    bus.length         = 8'd0;
    bus.volume         = 2'd3;
    bus.on             = 1'b1;
    bus.single         = 1'b0;
    bus.start          = 1'b0;
    bus.frequency      = 11'h7F8;
    #12;
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic trigger_play(input int vol);
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'hF0;
    bus.volume    = 2'(vol);
    bus.frequency = 11'h7F8;
    bus.on        = 1'b1;
    bus.start     = 1'b0;
    step();
    bus.start = 1'b1;
    step();
  endtask

  function automatic int exp_level(input int en, input int pos, input int vol);
    int b, nib;
    b   = int'(ram[pos / 2]);
    nib = (pos % 2 == 1) ? (b % 16) : (b / 16);
    if (en == 0 || vol == 0) return 0;
    return nib >> (vol - 1);
  endfunction

  initial begin
    tbl[0]  = '{3, 0,   3, 0,  1};
    tbl[1]  = '{3, 7,   3, 0,  1};
    tbl[2]  = '{3, 8,   0, 0,  1};
    tbl[3]  = '{3, 15,  0, 0,  1};
    tbl[4]  = '{3, 16,  3, 1,  1};
    tbl[5]  = '{3, 255, 0, 15, 1};
    tbl[6]  = '{3, 256, 3, 0,  1};
    tbl[7]  = '{1, 0,   15, 0, 1};
    tbl[8]  = '{1, 8,   0, 0,  1};
    tbl[9]  = '{2, 0,   7, 0,  1};
    tbl[10] = '{2, 9,   0, 0,  1};
    tbl[11] = '{0, 0,   0, 0,  1};
    tbl[12] = '{0, 100, 0, 6,  1};

    // reset state
    reset = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 8'hF0;
    #1;
    check("reset_enable", int'(bus.enable), 0);
    check("reset_level", int'(bus.level), 0);
    check("reset_addr", int'(bus.wave_addr), 0);

    // playback table
    for (int r = 0; r < 13; r++) begin
      trigger_play(tbl[r].vol);
      repeat (tbl[r].k) step();
      check($sformatf("tbl%0d_level", r), int'(bus.level), tbl[r].lvl);
      check($sformatf("tbl%0d_addr", r), int'(bus.wave_addr), tbl[r].addr);
      check($sformatf("tbl%0d_enable", r), int'(bus.enable), tbl[r].en);
    end

    // volume change is visible on level without a clock edge
    trigger_play(3);
    repeat (2) step();
    bus.volume = 2'd1;
    #1;
    check("vol_immediate_15", int'(bus.level), 15);
    bus.volume = 2'd2;
    #1;
    check("vol_immediate_7", int'(bus.level), 7);

    // asynchronous reset mid-play
    trigger_play(3);
    repeat (20) step();
    check("pre_reset_addr", int'(bus.wave_addr), 1);
    check("pre_reset_level", int'(bus.level), 3);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_enable", int'(bus.enable), 0);
    check("async_reset_level", int'(bus.level), 0);
    check("async_reset_addr", int'(bus.wave_addr), 0);
    @(negedge clk);
    reset = 1'b1;

    // DAC off, held start, trigger while off, clean retrigger
    trigger_play(3);
    repeat (3) step();
    bus.on = 1'b0;
    step();
    check("dac_off_enable", int'(bus.enable), 0);
    check("dac_off_level", int'(bus.level), 0);
    bus.on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("held_start_no_retrigger", int'(bus.enable), 0);
    end
    bus.start = 1'b0;
    step();
    bus.on    = 1'b0;
    bus.start = 1'b1;
    step();
    check("trigger_while_off", int'(bus.enable), 0);
    bus.on = 1'b1;
    step();
    check("on_with_start_high", int'(bus.enable), 0);
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    check("retrigger_enable", int'(bus.enable), 1);

`ifdef GB_CH3_LENGTH_EN
    // length timeout with single=1, then continuous with single=0
    for (int s = 1; s >= 0; s--) begin
      do_reset();
      bus.length = 8'hC8;
      bus.single = 1'(s);
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      for (int t = 1; t <= 300; t++) begin
        bus.clk_length_ctr = 1'b1;
        step();
        bus.clk_length_ctr = 1'b0;
        if (s == 1 && t <= 56)
          check($sformatf("len_single_tick%0d", t), int'(bus.enable), (t < 56) ? 1 : 0);
      end
      if (s == 0) check("len_continuous_300", int'(bus.enable), 1);
    end
    do_reset();
    bus.length = 8'hFF;
    bus.single = 1'b1;
    bus.start  = 1'b1;
    step();
    check("len255_pre", int'(bus.enable), 1);
    bus.clk_length_ctr = 1'b1;
    step();
    bus.clk_length_ctr = 1'b0;
    check("len255_one_tick", int'(bus.enable), 0);
`else
    // without the length feature, ticks never disable the channel
    do_reset();
    bus.length = 8'hFF;
    bus.single = 1'b1;
    bus.start  = 1'b1;
    step();
    for (int t = 0; t < 20; t++) begin
      bus.clk_length_ctr = 1'b1;
      step();
    end
    bus.clk_length_ctr = 1'b0;
    check("nolen_still_enabled", int'(bus.enable), 1);
`endif

    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    m_en = 0; m_pos = 0; m_rem = 0; m_len = 0; m_prev = 0;
    for (int c = 0; c < 4000; c++) begin
      int trig, expire, old_en;
      if ($urandom_range(0, 15) == 0) bus.start = ~bus.start;
      bus.on = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 31) == 0) bus.volume = 2'($urandom);
      if ($urandom_range(0, 99) == 0) bus.frequency = 11'(2036 + $urandom_range(0, 11));
      bus.clk_length_ctr = ($urandom_range(0, 7) == 0);
      bus.length = 8'(240 + $urandom_range(0, 15));
      bus.single = 1'($urandom_range(0, 1));
      @(posedge clk);
      trig   = (bus.start && m_prev == 0) ? 1 : 0;
      m_prev = int'(bus.start);
      old_en = m_en;
      expire = 0;
      if (bus.on && trig == 1) begin
        m_rem = 2048 - int'(bus.frequency);
        m_pos = 0;
        m_len = 256 - int'(bus.length);
      end else begin
        if (old_en == 1) begin
          m_rem--;
          if (m_rem == 0) begin
            m_pos = (m_pos + 1) % 32;
            m_rem = 2048 - int'(bus.frequency);
          end
        end
`ifdef GB_CH3_LENGTH_EN
        if (bus.clk_length_ctr && m_len > 0) begin
          m_len--;
          if (m_len == 0 && bus.single) expire = 1;
        end
`endif
      end
      if (!bus.on)            m_en = 0;
      else if (trig == 1)     m_en = 1;
      else if (expire == 1)   m_en = 0;
      else                    m_en = old_en;
      #1;
      check("rand_enable", int'(bus.enable), m_en);
      check("rand_addr", int'(bus.wave_addr), m_pos / 2);
      check("rand_level", int'(bus.level), exp_level(m_en, m_pos, int'(bus.volume)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/gb_custom_wave_channel.md
# gb_custom_wave_channel

Game Boy APU channel 3 (custom wave) generator. Steps through a 32-nibble wave table, 4 bits at a time, at a programmable rate. Applies a 2-bit volume shift and an optional length timeout. Sits beside the other APU channels: wave RAM lives outside the block and is read through `wave_addr`/`wave_data`, and `level` feeds the mixer.

## Interface
Parameters: none.

- `clk`  in  1  channel tick clock, rising edge; one frequency-timer step per cycle
- `reset`  in  1  asynchronous, active-low reset
- `clk_length_ctr`  in  1  one-cycle length-counter tick enable (256 Hz), synchronous to `clk`
- `length`  in  8  length load value; timeout = 256 − `length` ticks
- `volume`  in  2  00 mute, 01 100%, 10 50% (>>1), 11 25% (>>2)
- `on`  in  1  DAC power; 0 forces the channel off
- `single`  in  1  1 = stop when the length counter expires; 0 = play continuously
- `start`  in  1  trigger request, rising-edge sensitive
- `frequency`  in  11  period code; nibble period = 2048 − `frequency` clocks
- `wave_data`  in  8  wave RAM byte at `wave_addr`, combinational read; high nibble is played first
- `wave_addr`  out  4  wave RAM byte address = `pos[4:1]`
- `level`  out  4  current sample after volume shift; 0 when disabled
- `enable`  out  1  channel active status

## Operation
- State: `start_q` (edge detect), `enable`, 11-bit `timer`, 5-bit `pos`, 9-bit `len_cnt`.
- Trigger fires when `start & ~start_q`.
  - On trigger with `on=1`: `enable←1`, `timer←2048−frequency`, `pos←0`, `len_cnt←256−length`.
  - On trigger with `on=0`: no effect.
- `on=0` at any time: `enable←0` on the next edge.
- Frequency timer runs only while `enable=1`.
  - If `timer==1`: reload `2048−frequency` and `pos←pos+1`. `pos` wraps 31→0.
  - Otherwise: decrement `timer`.
- Sample selection: `pos[0]=0` selects `wave_data[7:4]`; `pos[0]=1` selects `wave_data[3:0]`.
- Output level, combinational: `level = enable ? (volume==0 ? 0 : nibble >> (volume−1)) : 0`.
- Length counter, acting on `clk_length_ctr=1`:
  - If `len_cnt≠0`: decrement it.
  - If it reaches 0 while `single=1`: `enable←0`.
  - If `single=0`: the counter still decrements but never disables the channel.
- Simultaneous events:
  - Trigger beats a length tick in the same cycle (reload wins).
  - `on=0` beats a trigger.
  - A frequency or volume change takes effect at the next timer reload; a volume change affects `level` immediately.

## Timing
- Reset (async, `reset=0`) clears all state:
  - `enable=0`, `level=0`, `wave_addr=0`.
  - `start_q=0`, `timer=0`, `pos=0`, `len_cnt=0`.
- Trigger latency: `start` sampled high at edge N (low at N−1) → `enable=1` after edge N.
- First `pos` advance after edge N+(2048−frequency).
- `wave_addr` and `level` change in the same cycle `pos` updates; no extra pipeline stage.
- `frequency=2047` → advance every clock. `frequency=0` → every 2048 clocks.
- `length=0` → 256 ticks to timeout. `length=255` → 1 tick.
- Holding `start` high retriggers nothing; it must go low and rise again.

## Configuration
- `GB_CH3_LENGTH_EN` defined: the length counter and `single` behave as described above.
- `GB_CH3_LENGTH_EN` undefined:
  - Length counter is removed.
  - `clk_length_ctr`, `length` and `single` are ignored.
  - Channel stays enabled until `on=0` or reset.

## Test plan
- Reset: assert `reset=0` mid-play → `enable=0`, `level=0`, `wave_addr=0` immediately, without waiting for a clock edge.
- Playback, all bytes 0xF0, `frequency=0x7F8`, `volume=11`, `on=1`, trigger:
  - `level` is 3 for 8 clocks, then 0 for 8 clocks, repeating.
  - `wave_addr` increments every 16 clocks and wraps 15→0.
- Volume: same setup with `volume=01` → `level` toggles 15/0. With `volume=10` → 7/0. With `volume=00` → constant 0 while `enable=1`.
- Length (`GB_CH3_LENGTH_EN`): `length=0xC8`, `single=1`, trigger, then pulse `clk_length_ctr` → `enable` stays 1 through 55 ticks and drops after the 56th. With `single=0` → `enable` is still 1 after 300 ticks.
- DAC/edge:
  - Hold `start=1` for 10 cycles after `on` drops and returns → no retrigger.
  - `on=0` → `enable=0` next edge, `level=0`.
  - Trigger while `on=0` → `enable` remains 0.
